// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: sequences reads of the 1-bit-address system-ID slave,
// checks the ID and timestamp words against expected values and reports
// pass flags, a mismatch pulse and a saturating mismatch count.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1374738911,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned RECHECK_PERIOD = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        done,
    output logic        busy,
    output logic        mismatch_irq,
    output logic [7:0]  mismatch_count
);

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_RD_ID,
        ST_RD_TS,
        ST_COMPARE,
        ST_WAIT
    } state_e;

    localparam logic [19:0] SETTLE_RELOAD = 20'(SETTLE_CYCLES - 1);
    localparam logic [19:0] WAIT_RELOAD   = (RECHECK_PERIOD == 0) ? 20'd0 : 20'(RECHECK_PERIOD - 1);
    localparam logic        RECHECK_EN    = (RECHECK_PERIOD != 0);

    state_e      state_q;
    logic [19:0] cnt_q;
    logic        pending_q;
    logic        addr_q;
    logic [31:0] id_value_q;
    logic [31:0] ts_value_q;
    logic        id_ok_q;
    logic        ts_ok_q;
    logic        done_q;
    logic        busy_q;
    logic        irq_q;
    logic [7:0]  count_q;

    logic        id_match_d;
    logic        ts_match_d;

    // Full-width comparison of the captured words against the expected values
    always_comb begin
        id_match_d = (id_value_q == EXPECTED_ID);
        ts_match_d = (ts_value_q == EXPECTED_TS);
    end

    // Check sequencer: settle, read both words, compare, then wait for a recheck
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_SETTLE;
            cnt_q      <= SETTLE_RELOAD;
            pending_q  <= 1'b0;
            addr_q     <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            irq_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            irq_q <= 1'b0;
            case (state_q)
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q   <= ST_RD_ID;
                        pending_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 20'd1;
                    end
                end
                ST_RD_ID: begin
                    id_value_q <= sysid_readdata;
                    addr_q     <= 1'b1;
                    state_q    <= ST_RD_TS;
                    if (start) pending_q <= 1'b1;
                end
                ST_RD_TS: begin
                    ts_value_q <= sysid_readdata;
                    addr_q     <= 1'b0;
                    state_q    <= ST_COMPARE;
                    if (start) pending_q <= 1'b1;
                end
                ST_COMPARE: begin
                    id_ok_q <= id_match_d;
                    ts_ok_q <= ts_match_d;
                    done_q  <= 1'b1;
                    cnt_q   <= WAIT_RELOAD;
                    if (!(id_match_d && ts_match_d)) begin
                        irq_q <= 1'b1;
                        if (count_q != 8'hFF) count_q <= count_q + 8'd1;
                    end
                    // A start seen in this same cycle counts as pending so it is not lost
                    if (pending_q || start) begin
                        state_q   <= ST_RD_ID;
                        pending_q <= 1'b0;
                    end else begin
                        state_q <= ST_WAIT;
                        busy_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (start || (RECHECK_EN && cnt_q == '0)) begin
                        state_q   <= ST_RD_ID;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 20'd1;
                    end
                end
                default: begin
                    state_q <= ST_SETTLE;
                    cnt_q   <= SETTLE_RELOAD;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign sysid_address  = addr_q;
    assign id_value       = id_value_q;
    assign ts_value       = ts_value_q;
    assign id_ok          = id_ok_q;
    assign ts_ok          = ts_ok_q;
    assign done           = done_q;
    assign busy           = busy_q;
    assign mismatch_irq   = irq_q;
    assign mismatch_count = count_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: two instances (recheck period 16 and 0) share
// clock, reset, start and the emulated sysid slave words, and are checked
// every cycle against a behavioural model plus a few literal expectations.
module tb_sysid_check_ctrl;

    localparam logic [31:0] EID   = 32'd0;
    localparam logic [31:0] ETS   = 32'd1374738911;
    localparam int          PER_A = 16;
    localparam int          PER_B = 0;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] id_word;
    logic [31:0] ts_word;

    logic        a_addr, b_addr;
    logic [31:0] rd_a, rd_b;
    logic [31:0] a_id, a_ts, b_id, b_ts;
    logic        a_idok, a_tsok, a_done, a_busy, a_irq;
    logic        b_idok, b_tsok, b_done, b_busy, b_irq;
    logic [7:0]  a_cnt, b_cnt;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    always #5 clock = ~clock;

    // Emulated slave: data is a combinational function of the address
    assign rd_a = a_addr ? ts_word : id_word;
    assign rd_b = b_addr ? ts_word : id_word;

    sysid_check_ctrl #(.RECHECK_PERIOD(PER_A)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start),
        .sysid_address(a_addr), .sysid_readdata(rd_a),
        .id_value(a_id), .ts_value(a_ts), .id_ok(a_idok), .ts_ok(a_tsok),
        .done(a_done), .busy(a_busy), .mismatch_irq(a_irq), .mismatch_count(a_cnt)
    );

    sysid_check_ctrl #(.RECHECK_PERIOD(PER_B)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start),
        .sysid_address(b_addr), .sysid_readdata(rd_b),
        .id_value(b_id), .ts_value(b_ts), .id_ok(b_idok), .ts_ok(b_tsok),
        .done(b_done), .busy(b_busy), .mismatch_irq(b_irq), .mismatch_count(b_cnt)
    );

    // ---------------- behavioural model ----------------
    // A check is three cycles: fetch word 0, fetch word 1, judge.
    // m_step = -1 means idle (waiting for a trigger).
    int          m_settle [2];
    bit          m_settling [2];
    int          m_step [2];
    bit          m_again [2];
    int          m_wait [2];
    bit          e_addr [2];
    logic [31:0] e_id [2];
    logic [31:0] e_ts [2];
    bit          e_idok [2];
    bit          e_tsok [2];
    bit          e_done [2];
    bit          e_busy [2];
    bit          e_irq [2];
    int          e_cnt [2];

    function automatic int per(input int i);
        return (i == 0) ? PER_A : PER_B;
    endfunction

    task automatic model_reset(input int i);
        m_settle[i]   = 3;
        m_settling[i] = 1'b1;
        m_step[i]     = -1;
        m_again[i]    = 1'b0;
        m_wait[i]     = 0;
        e_addr[i]     = 1'b0;
        e_id[i]       = '0;
        e_ts[i]       = '0;
        e_idok[i]     = 1'b0;
        e_tsok[i]     = 1'b0;
        e_done[i]     = 1'b0;
        e_busy[i]     = 1'b1;
        e_irq[i]      = 1'b0;
        e_cnt[i]      = 0;
    endtask

    task automatic model_step(input int i);
        e_irq[i] = 1'b0;
        if (m_settling[i]) begin
            if (m_settle[i] == 0) begin
                m_settling[i] = 1'b0;
                m_step[i]     = 0;
                m_again[i]    = 1'b0;
            end else begin
                m_settle[i] = m_settle[i] - 1;
            end
        end else if (m_step[i] == 0) begin
            e_id[i]   = id_word;
            e_addr[i] = 1'b1;
            m_step[i] = 1;
            if (start) m_again[i] = 1'b1;
        end else if (m_step[i] == 1) begin
            e_ts[i]   = ts_word;
            e_addr[i] = 1'b0;
            m_step[i] = 2;
            if (start) m_again[i] = 1'b1;
        end else if (m_step[i] == 2) begin
            e_idok[i] = (e_id[i] == EID);
            e_tsok[i] = (e_ts[i] == ETS);
            e_done[i] = 1'b1;
            m_wait[i] = per(i) - 1;
            if (!(e_idok[i] && e_tsok[i])) begin
                e_irq[i] = 1'b1;
                if (e_cnt[i] < 255) e_cnt[i] = e_cnt[i] + 1;
            end
            if (m_again[i] || start) begin
                m_step[i]  = 0;
                m_again[i] = 1'b0;
            end else begin
                m_step[i] = -1;
            end
        end else begin
            if (start || (per(i) != 0 && m_wait[i] == 0)) begin
                m_step[i]  = 0;
                m_again[i] = 1'b0;
            end else begin
                m_wait[i] = m_wait[i] - 1;
            end
        end
        e_busy[i] = m_settling[i] || (m_step[i] != -1);
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clock or negedge reset_n);
            for (int i = 0; i < 2; i++) begin
                if (!reset_n) model_reset(i);
                else model_step(i);
            end
        end
    end

    // ---------------- comparison ----------------
    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (cmp_en) begin
                cmp("a.addr", 32'(a_addr), 32'(e_addr[0]));
                cmp("a.id_value", a_id, e_id[0]);
                cmp("a.ts_value", a_ts, e_ts[0]);
                cmp("a.id_ok", 32'(a_idok), 32'(e_idok[0]));
                cmp("a.ts_ok", 32'(a_tsok), 32'(e_tsok[0]));
                cmp("a.done", 32'(a_done), 32'(e_done[0]));
                cmp("a.busy", 32'(a_busy), 32'(e_busy[0]));
                cmp("a.irq", 32'(a_irq), 32'(e_irq[0]));
                cmp("a.count", 32'(a_cnt), 32'(e_cnt[0]));
                cmp("b.addr", 32'(b_addr), 32'(e_addr[1]));
                cmp("b.id_value", b_id, e_id[1]);
                cmp("b.ts_value", b_ts, e_ts[1]);
                cmp("b.id_ok", 32'(b_idok), 32'(e_idok[1]));
                cmp("b.ts_ok", 32'(b_tsok), 32'(e_tsok[1]));
                cmp("b.done", 32'(b_done), 32'(e_done[1]));
                cmp("b.busy", 32'(b_busy), 32'(e_busy[1]));
                cmp("b.irq", 32'(b_irq), 32'(e_irq[1]));
                cmp("b.count", 32'(b_cnt), 32'(e_cnt[1]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(posedge clock); #2 reset_n = 1'b0;
        @(posedge clock); #2 reset_n = 1'b1;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        int nb;
        reset_n = 1'b0;
        start   = 1'b0;
        id_word = EID;
        ts_word = ETS;
        repeat (2) @(posedge clock);
        #2 cmp_en = 1'b1;

        // Reset state
        @(negedge clock);
        cmp("rst.done", 32'(a_done), 32'd0);
        cmp("rst.busy", 32'(a_busy), 32'd1);

        // Good slave: flags valid after edge 7, not before
        @(posedge clock); #2 reset_n = 1'b1;
        edges(6);
        cmp("good.done_e6", 32'(a_done), 32'd0);
        edges(1);
        cmp("good.done_e7", 32'(a_done), 32'd1);
        cmp("good.id_ok", 32'(a_idok), 32'd1);
        cmp("good.ts_ok", 32'(a_tsok), 32'd1);
        cmp("good.count", 32'(a_cnt), 32'd0);
        cmp("good.irq", 32'(a_irq), 32'd0);

        // Bad timestamp: one pulse at edge 7, count 1
        ts_word = 32'h12345678;
        do_reset();
        edges(6);
        cmp("bad.irq_e6", 32'(a_irq), 32'd0);
        edges(1);
        cmp("bad.id_ok", 32'(a_idok), 32'd1);
        cmp("bad.ts_ok", 32'(a_tsok), 32'd0);
        cmp("bad.irq_e7", 32'(a_irq), 32'd1);
        cmp("bad.count", 32'(a_cnt), 32'd1);
        cmp("bad.ts_value", a_ts, 32'h12345678);
        edges(1);
        cmp("bad.irq_e8", 32'(a_irq), 32'd0);

        // Persistent mismatch: period-16 instance saturates, period-0 checks once
        edges(5800);
        cmp("sat.count_a", 32'(a_cnt), 32'd255);
        cmp("sat.count_b", 32'(b_cnt), 32'd1);

        // start held through SETTLE gives a single check
        do_reset();
        start = 1'b1;
        repeat (4) @(posedge clock);
        #2 start = 1'b0;
        nb = 0;
        repeat (30) begin
            @(negedge clock);
            if (b_addr) nb++;
        end
        cmp("settle_start.reads_b", 32'(nb), 32'd1);
        cmp("settle_start.count_b", 32'(b_cnt), 32'd1);

        // start in WAIT, then again during RD_TS: two back-to-back checks
        @(posedge clock); #2 start = 1'b1;
        @(posedge clock); #2 start = 1'b0;
        @(posedge clock); #2 start = 1'b1;
        @(posedge clock); #2 start = 1'b0;
        edges(10);
        cmp("b2b.count_b", 32'(b_cnt), 32'd3);
        cmp("b2b.busy_b", 32'(b_busy), 32'd0);

        // Randomized traffic with occasional word changes and reset pulses
        for (int k = 0; k < 3000; k++) begin
            @(posedge clock); #2;
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 47) == 0)
                ts_word = ($urandom_range(0, 1) == 0) ? ETS : $urandom;
            if ($urandom_range(0, 63) == 0)
                id_word = ($urandom_range(0, 2) != 0) ? EID : $urandom;
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
        end

        // Reset during RD_TS clears everything at once, then restarts
        start   = 1'b0;
        reset_n = 1'b1;
        id_word = EID;
        ts_word = ETS;
        do_reset();
        repeat (5) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        cmp("midrst.addr", 32'(a_addr), 32'd0);
        cmp("midrst.id_value", a_id, 32'd0);
        cmp("midrst.done", 32'(a_done), 32'd0);
        cmp("midrst.busy", 32'(a_busy), 32'd1);
        cmp("midrst.count", 32'(a_cnt), 32'd0);
        @(posedge clock); #2 reset_n = 1'b1;
        edges(6);
        cmp("midrst.done_e6", 32'(a_done), 32'd0);
        edges(1);
        cmp("midrst.done_e7", 32'(a_done), 32'd1);
        cmp("midrst.id_ok", 32'(a_idok), 32'd1);
        cmp("midrst.ts_ok", 32'(a_tsok), 32'd1);

        @(posedge clock); #2 cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
